// File: rtl/aes_enc_iter_umsk_if.sv
// Handshake and data bundle for the iterative AES-128 encryption core.
// out_last_key exists only when AES_LAST_KEY_OUT_EN is defined.

// Valid/ready: a transfer happens on a rising clock edge where valid and ready
// are both high. The producer keeps valid and its data stable until that edge.
// valid never waits for ready.
interface aes_enc_iter_umsk_if;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_plaintext;
  logic [127:0] in_key;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_ciphertext;
  logic         busy;
  logic [1:0]   dbg_state;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] out_last_key;
`endif

  modport master (
    output in_valid, in_plaintext, in_key, out_ready,
    input  in_ready, out_valid, out_ciphertext, busy, dbg_state
`ifdef AES_LAST_KEY_OUT_EN
    , input out_last_key
`endif
  );

  modport slave (
    input  in_valid, in_plaintext, in_key, out_ready,
    output in_ready, out_valid, out_ciphertext, busy, dbg_state
`ifdef AES_LAST_KEY_OUT_EN
    , output out_last_key
`endif
  );
endinterface

// File: rtl/aes_enc_iter_umsk.sv
// Iterative unmasked AES-128 encryptor, RPC rounds per clock, IDLE/BUSY/DONE sequencing.
// Optional AES_LAST_KEY_OUT_EN adds out_last_key (round-10 key, registered with the ciphertext).
module aes_enc_iter_umsk #(
  parameter int RPC = 1
) (
  input  logic clk,
  input  logic rst_n,
  aes_enc_iter_umsk_if.slave bus
);

  if (RPC != 1 && RPC != 2 && RPC != 5 && RPC != 10) begin : g_rpc_check
    $error("aes_enc_iter_umsk: RPC must be 1, 2, 5 or 10");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Byte i of a 128-bit block sits at bits [8i+7:8i]; column c holds bytes 4c..4c+3.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // S-box as inverse (x^254, zero maps to zero) followed by the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq;
    logic [7:0] inv;
    sq  = gf_mul(x, x);
    inv = sq;
    for (int i = 0; i < 6; i++) begin
      sq  = gf_mul(sq, sq);
      inv = gf_mul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
           {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = sbox(x[8*i +: 8]);
    return y;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] x);
    logic [127:0] y;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        y[8*(r + 4*c) +: 8] = x[8*(r + 4*((c + r) % 4)) +: 8];
      end
    end
    return y;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] x);
    logic [127:0] y;
    logic [7:0]   a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = x[32*c      +: 8];
      a1 = x[32*c + 8  +: 8];
      a2 = x[32*c + 16 +: 8];
      a3 = x[32*c + 24 +: 8];
      y[32*c      +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      y[32*c + 8  +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      y[32*c + 16 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      y[32*c + 24 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return y;
  endfunction

  // One key-schedule step: RotWord of w3 is a right rotate by one byte in this packing.
  function automatic logic [127:0] key_step(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] rot;
    logic [31:0] t;
    logic [31:0] w0, w1, w2, w3;
    rot = {k[103:96], k[127:104]};
    t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0]) ^ rc};
    w0  = k[31:0]   ^ t;
    w1  = k[63:32]  ^ w0;
    w2  = k[95:64]  ^ w1;
    w3  = k[127:96] ^ w2;
    return {w3, w2, w1, w0};
  endfunction

  state_e       state_q, state_d;
  logic [127:0] st_q, st_d;
  logic [127:0] key_q, key_d;
  logic [127:0] ct_q, ct_d;
  logic [7:0]   rcon_q, rcon_d;
  logic [3:0]   cnt_q, cnt_d;
`ifdef AES_LAST_KEY_OUT_EN
  logic [127:0] lk_q, lk_d;
`endif

  logic [127:0] rnd_st;
  logic [127:0] rnd_key;
  logic [7:0]   rnd_rcon;
  logic         rnd_last;
  logic         fin;
  logic         in_ready;
  logic         accept;

  // Chain of RPC round stages; the stage that completes round 10 skips MixColumns and adds k10.
  always_comb begin
    rnd_st   = st_q;
    rnd_key  = key_q;
    rnd_rcon = rcon_q;
    rnd_last = 1'b0;
    for (int i = 0; i < RPC; i++) begin
      rnd_last = (({1'b0, cnt_q} + 5'(i) + 5'd1) == 5'd10);
      rnd_st   = shift_rows(sub_bytes(rnd_st ^ rnd_key));
      if (!rnd_last) rnd_st = mix_columns(rnd_st);
      rnd_key  = key_step(rnd_key, rnd_rcon);
      rnd_rcon = xtime(rnd_rcon);
      if (rnd_last) rnd_st = rnd_st ^ rnd_key;
    end
  end

  assign fin      = (({1'b0, cnt_q} + 5'(RPC)) == 5'd10);
  assign in_ready = (state_q == S_IDLE) || ((state_q == S_DONE) && bus.out_ready);
  assign accept   = in_ready && bus.in_valid;

  always_comb begin
    state_d = state_q;
    st_d    = st_q;
    key_d   = key_q;
    ct_d    = ct_q;
    rcon_d  = rcon_q;
    cnt_d   = cnt_q;
`ifdef AES_LAST_KEY_OUT_EN
    lk_d    = lk_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (accept) begin
          st_d    = bus.in_plaintext;
          key_d   = bus.in_key;
          rcon_d  = 8'h01;
          cnt_d   = 4'd0;
          state_d = S_BUSY;
        end else if (state_q == S_DONE && bus.out_ready) begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        st_d   = rnd_st;
        key_d  = rnd_key;
        rcon_d = rnd_rcon;
        cnt_d  = cnt_q + 4'(RPC);
        if (fin) begin
          ct_d    = rnd_st;
`ifdef AES_LAST_KEY_OUT_EN
          lk_d    = rnd_key;
`endif
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      st_q    <= '0;
      key_q   <= '0;
      ct_q    <= '0;
      rcon_q  <= 8'h01;
      cnt_q   <= 4'd0;
`ifdef AES_LAST_KEY_OUT_EN
      lk_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      st_q    <= st_d;
      key_q   <= key_d;
      ct_q    <= ct_d;
      rcon_q  <= rcon_d;
      cnt_q   <= cnt_d;
`ifdef AES_LAST_KEY_OUT_EN
      lk_q    <= lk_d;
`endif
    end
  end

  assign bus.in_ready       = in_ready;
  assign bus.out_valid      = (state_q == S_DONE);
  assign bus.busy           = (state_q == S_BUSY);
  assign bus.out_ciphertext = ct_q;
  assign bus.dbg_state      = state_q;
`ifdef AES_LAST_KEY_OUT_EN
  assign bus.out_last_key   = lk_q;
`endif

endmodule

// File: tb/tb_aes_enc_iter_umsk.sv
// Bench for aes_enc_iter_umsk: FIPS-197 known answers, latency, stall, back-to-back,
// mid-block reset and RPC 1/2/5/10 variants.
module tb_aes_enc_iter_umsk;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_LK  = 128'h13111d7fe3944a17f307a78b4d2b30c5;
  localparam logic [127:0] B_KEY  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] B_PT   = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] B_CT   = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] B_LK   = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

  // Clock / reset
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  aes_enc_iter_umsk_if b1 ();
  aes_enc_iter_umsk_if b2 ();
  aes_enc_iter_umsk_if b5 ();
  aes_enc_iter_umsk_if b10 ();

  aes_enc_iter_umsk #(.RPC(1))  dut1  (.clk(clk), .rst_n(rst_n), .bus(b1));
  aes_enc_iter_umsk #(.RPC(2))  dut2  (.clk(clk), .rst_n(rst_n), .bus(b2));
  aes_enc_iter_umsk #(.RPC(5))  dut5  (.clk(clk), .rst_n(rst_n), .bus(b5));
  aes_enc_iter_umsk #(.RPC(10)) dut10 (.clk(clk), .rst_n(rst_n), .bus(b10));

  int n_cmp  = 0;
  int n_fail = 0;

  // FIPS strings list byte 0 first; the core puts byte 0 in bits [7:0].
  function automatic logic [127:0] brev(input logic [127:0] x);
    logic [127:0] y;
    for (int i = 0; i < 16; i++) y[8*i +: 8] = x[8*(15-i) +: 8];
    return y;
  endfunction

  function automatic logic [127:0] known_ct(input logic [127:0] pt, input logic [127:0] key);
    if (pt == brev(C1_PT) && key == brev(C1_KEY)) return brev(C1_CT);
    if (pt == brev(B_PT)  && key == brev(B_KEY))  return brev(B_CT);
    return 'x;
  endfunction

  function automatic logic [127:0] known_lk(input logic [127:0] key);
    if (key == brev(C1_KEY)) return brev(C1_LK);
    if (key == brev(B_KEY))  return brev(B_LK);
    return 'x;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic chki(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Transaction model for the RPC=1 instance: phase 0 idle, 1 computing, 2 result held.
  int           m_phase = 0;
  int           m_left  = 0;
  logic [127:0] exp_q[$];
  logic [127:0] expk_q[$];

  task automatic m_accept();
    exp_q.push_back(known_ct(b1.in_plaintext, b1.in_key));
    expk_q.push_back(known_lk(b1.in_key));
    m_phase = 1;
    m_left  = 10;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = 0;
      m_left  = 0;
      exp_q.delete();
      expk_q.delete();
    end else begin
      case (m_phase)
        0: if (b1.in_valid) m_accept();
        1: begin
          m_left--;
          if (m_left == 0) m_phase = 2;
        end
        default: if (b1.out_ready) begin
          if (exp_q.size() > 0)  void'(exp_q.pop_front());
          if (expk_q.size() > 0) void'(expk_q.pop_front());
          if (b1.in_valid) m_accept();
          else m_phase = 0;
        end
      endcase
    end
  end

  // Scoreboard compare, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      chkb("sb out_valid", b1.out_valid, m_phase == 2);
      chkb("sb in_ready", b1.in_ready, (m_phase == 0) || (m_phase == 2 && b1.out_ready));
      chkb("sb busy", b1.busy, m_phase == 1);
      if (m_phase == 2 && exp_q.size() > 0) chk("sb ct", b1.out_ciphertext, exp_q[0]);
`ifdef AES_LAST_KEY_OUT_EN
      if (m_phase == 2 && expk_q.size() > 0) chk("sb last_key", b1.out_last_key, expk_q[0]);
`endif
    end
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wait_valid(input int bound, output int n);
    n = 0;
    while (n < bound) begin
      tick();
      n++;
      if (b1.out_valid) return;
    end
    n = -1;
  endtask

  task automatic offer(input logic [127:0] pt_f, input logic [127:0] key_f);
    b1.in_plaintext = brev(pt_f);
    b1.in_key       = brev(key_f);
    b1.in_valid     = 1'b1;
  endtask

  int n;
  int lat2, lat5, lat10;

  initial begin
    b1.in_valid = 1'b0;  b1.in_plaintext = '0;  b1.in_key = '0;  b1.out_ready = 1'b1;
    b2.in_valid = 1'b0;  b2.in_plaintext = '0;  b2.in_key = '0;  b2.out_ready = 1'b1;
    b5.in_valid = 1'b0;  b5.in_plaintext = '0;  b5.in_key = '0;  b5.out_ready = 1'b1;
    b10.in_valid = 1'b0; b10.in_plaintext = '0; b10.in_key = '0; b10.out_ready = 1'b1;

    #3;
    chkb("rst in_ready", b1.in_ready, 1'b1);
    chkb("rst out_valid", b1.out_valid, 1'b0);
    chkb("rst busy", b1.busy, 1'b0);
    chk("rst ct", b1.out_ciphertext, 128'h0);
`ifdef AES_LAST_KEY_OUT_EN
    chk("rst last_key", b1.out_last_key, 128'h0);
`endif
    #20 rst_n = 1'b1;

    // C.1 with latency; inputs scrambled right after accept
    tick();
    offer(C1_PT, C1_KEY);
    tick();
    b1.in_valid     = 1'b0;
    b1.in_plaintext = {4{32'hdeadbeef}};
    b1.in_key       = {4{32'h5a5aa5a5}};
    wait_valid(20, n);
    chki("c1 latency", n, 10);
    chk("c1 ct", b1.out_ciphertext, brev(C1_CT));
`ifdef AES_LAST_KEY_OUT_EN
    chk("c1 last_key", b1.out_last_key, brev(C1_LK));
`endif
    tick();

    // App.B with a 20-cycle output stall and ignored in_valid pulses
    b1.out_ready = 1'b0;
    offer(B_PT, B_KEY);
    tick();
    b1.in_valid = 1'b0;
    wait_valid(20, n);
    chki("appb latency", n, 10);
    chk("appb ct", b1.out_ciphertext, brev(B_CT));
`ifdef AES_LAST_KEY_OUT_EN
    chk("appb last_key", b1.out_last_key, brev(B_LK));
`endif
    for (int i = 0; i < 20; i++) begin
      if (i % 2 == 0) offer(C1_PT, C1_KEY);
      else b1.in_valid = 1'b0;
      tick();
      chkb("stall out_valid", b1.out_valid, 1'b1);
      chkb("stall in_ready", b1.in_ready, 1'b0);
      chk("stall ct", b1.out_ciphertext, brev(B_CT));
    end
    b1.in_valid  = 1'b0;
    b1.out_ready = 1'b1;
    tick();
    chkb("stall release", b1.out_valid, 1'b0);

    // Back-to-back C.1 blocks with in_valid held high
    offer(C1_PT, C1_KEY);
    tick();
    wait_valid(20, n);
    chki("b2b first latency", n, 10);
    chkb("b2b ready in done", b1.in_ready, 1'b1);
    wait_valid(20, n);
    b1.in_valid = 1'b0;
    chki("b2b gap", n, 11);
    chk("b2b second ct", b1.out_ciphertext, brev(C1_CT));
    tick();

    // Reset in the middle of a block
    offer(C1_PT, C1_KEY);
    tick();
    b1.in_valid = 1'b0;
    repeat (5) tick();
    chkb("pre-reset busy", b1.busy, 1'b1);
    rst_n = 1'b0;
    #1;
    chkb("mid rst out_valid", b1.out_valid, 1'b0);
    chkb("mid rst in_ready", b1.in_ready, 1'b1);
    chkb("mid rst busy", b1.busy, 1'b0);
    #4 rst_n = 1'b1;
    tick();
    offer(C1_PT, C1_KEY);
    tick();
    b1.in_valid = 1'b0;
    wait_valid(20, n);
    chki("post-rst latency", n, 10);
    chk("post-rst ct", b1.out_ciphertext, brev(C1_CT));
    tick();

    // RPC 2/5/10 with App.B
    b2.in_plaintext  = brev(B_PT); b2.in_key  = brev(B_KEY); b2.in_valid  = 1'b1;
    b5.in_plaintext  = brev(B_PT); b5.in_key  = brev(B_KEY); b5.in_valid  = 1'b1;
    b10.in_plaintext = brev(B_PT); b10.in_key = brev(B_KEY); b10.in_valid = 1'b1;
    tick();
    b2.in_valid = 1'b0; b5.in_valid = 1'b0; b10.in_valid = 1'b0;
    lat2 = -1; lat5 = -1; lat10 = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (b2.out_valid && lat2 < 0) begin
        lat2 = i;
        chk("rpc2 ct", b2.out_ciphertext, brev(B_CT));
`ifdef AES_LAST_KEY_OUT_EN
        chk("rpc2 last_key", b2.out_last_key, brev(B_LK));
`endif
      end
      if (b5.out_valid && lat5 < 0) begin
        lat5 = i;
        chk("rpc5 ct", b5.out_ciphertext, brev(B_CT));
`ifdef AES_LAST_KEY_OUT_EN
        chk("rpc5 last_key", b5.out_last_key, brev(B_LK));
`endif
      end
      if (b10.out_valid && lat10 < 0) begin
        lat10 = i;
        chk("rpc10 ct", b10.out_ciphertext, brev(B_CT));
`ifdef AES_LAST_KEY_OUT_EN
        chk("rpc10 last_key", b10.out_last_key, brev(B_LK));
`endif
      end
    end
    chki("rpc2 latency", lat2, 5);
    chki("rpc5 latency", lat5, 2);
    chki("rpc10 latency", lat10, 1);

    repeat (3) tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
